// File: rtl/writeback_queue.sv
// rtl/writeback_queue.sv - register-file writeback FIFO with read-port forwarding
// Memory results win arbitration; head drains one entry per cycle into the register file.
module writeback_queue #(
  parameter int width = 16,
  parameter int depth = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     mem_valid,
  input  logic [2:0]               mem_addr,
  input  logic [width-1:0]         mem_data,
  output logic                     mem_ready,
  input  logic                     alu_valid,
  input  logic [2:0]               alu_addr,
  input  logic [width-1:0]         alu_data,
  output logic                     alu_ready,
  output logic                     write_en,
  output logic [2:0]               write_addr,
  output logic [width-1:0]         data_in,
  input  logic [2:0]               read_addr_a,
  input  logic [2:0]               read_addr_b,
  output logic                     fwd_hit_a,
  output logic                     fwd_hit_b,
  output logic [width-1:0]         fwd_data_a,
  output logic [width-1:0]         fwd_data_b,
  output logic [$clog2(depth):0]   pending
);

  localparam int aw = $clog2(depth);
  localparam logic [aw:0] full_count = (aw+1)'(depth);

  logic [2:0]       addr_q [depth];
  logic [width-1:0] data_q [depth];
  logic [aw-1:0]    wr_ptr;
  logic [aw-1:0]    rd_ptr;
  logic [aw:0]      count;

  logic             full;
  logic             empty;
  logic             mem_take;
  logic             alu_take;
  logic             enq;
  logic             pop;
  logic [2:0]       enq_addr;
  logic [width-1:0] enq_data;

  assign full      = (count == full_count);
  assign empty     = (count == '0);
  assign mem_ready = !full;
  assign alu_ready = !full && !mem_valid;
  assign mem_take  = mem_valid && mem_ready;
  assign alu_take  = !mem_take && alu_valid && alu_ready;
  assign enq_addr  = mem_take ? mem_addr : alu_addr;
  assign enq_data  = mem_take ? mem_data : alu_data;
  // Writes to r0 are handshaken but dropped so r0 never reaches the register file.
  assign enq       = (mem_take || alu_take) && (enq_addr != 3'd0);
  assign pop       = !empty;

  assign write_en   = !empty;
  assign write_addr = empty ? 3'd0 : addr_q[rd_ptr];
  assign data_in    = empty ? '0   : data_q[rd_ptr];
  assign pending    = count;

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < depth; i++) begin
        addr_q[i] <= 3'd0;
        data_q[i] <= '0;
      end
    end else begin
      if (enq) begin
        addr_q[wr_ptr] <= enq_addr;
        data_q[wr_ptr] <= enq_data;
        wr_ptr         <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (enq && !pop) begin
        count <= count + 1'b1;
      end else if (pop && !enq) begin
        count <= count - 1'b1;
      end
    end
  end

  // Walk oldest to youngest so the last match seen is the youngest pending value.
  function automatic logic [width:0] lookup(input logic [2:0] ra);
    logic [width:0] res;
    logic [aw-1:0]  idx;
    res = '0;
    for (int i = 0; i < depth; i++) begin
      idx = rd_ptr + aw'(i);
      if ((ra != 3'd0) && ((aw+1)'(i) < count) && (addr_q[idx] == ra)) begin
        res = {1'b1, data_q[idx]};
      end
    end
    return res;
  endfunction

  always_comb begin
    {fwd_hit_a, fwd_data_a} = lookup(read_addr_a);
    {fwd_hit_b, fwd_data_b} = lookup(read_addr_b);
  end

endmodule

// File: tb/tb_writeback_queue.sv
// tb/tb_writeback_queue.sv - checks writeback_queue against a queue-based reference
// Directed scenarios first, then randomized traffic with occasional resets.
module tb_writeback_queue;

  localparam int width = 16;
  localparam int depth = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic             mem_valid, alu_valid;
  logic [2:0]       mem_addr, alu_addr;
  logic [width-1:0] mem_data, alu_data;
  logic             mem_ready, alu_ready;
  logic             write_en;
  logic [2:0]       write_addr;
  logic [width-1:0] data_in;
  logic [2:0]       read_addr_a, read_addr_b;
  logic             fwd_hit_a, fwd_hit_b;
  logic [width-1:0] fwd_data_a, fwd_data_b;
  logic [$clog2(depth):0] pending;

  int checks = 0;
  int errors = 0;

  logic [2:0]       q_addr [$];
  logic [width-1:0] q_data [$];

  always #5 clk = ~clk;

  writeback_queue #(.width(width), .depth(depth)) dut (
    .clk(clk), .reset(reset),
    .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_data(mem_data), .mem_ready(mem_ready),
    .alu_valid(alu_valid), .alu_addr(alu_addr), .alu_data(alu_data), .alu_ready(alu_ready),
    .write_en(write_en), .write_addr(write_addr), .data_in(data_in),
    .read_addr_a(read_addr_a), .read_addr_b(read_addr_b),
    .fwd_hit_a(fwd_hit_a), .fwd_hit_b(fwd_hit_b),
    .fwd_data_a(fwd_data_a), .fwd_data_b(fwd_data_b),
    .pending(pending)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_fwd(input logic [2:0] ra, output logic hit, output logic [width-1:0] d);
    hit = 1'b0;
    d   = '0;
    foreach (q_addr[i]) begin
      if (ra != 3'd0 && q_addr[i] == ra) begin
        hit = 1'b1;
        d   = q_data[i];
      end
    end
  endtask

  task automatic step(input logic rst,
                      input logic mv, input logic [2:0] ma, input logic [width-1:0] md,
                      input logic av, input logic [2:0] aa, input logic [width-1:0] ad,
                      input logic [2:0] ra, input logic [2:0] rb);
    logic             full, e_mr, e_ar, hit;
    logic [width-1:0] fd;
    @(posedge clk);
    #1;
    reset = rst;
    mem_valid = mv; mem_addr = ma; mem_data = md;
    alu_valid = av; alu_addr = aa; alu_data = ad;
    read_addr_a = ra; read_addr_b = rb;
    @(negedge clk);
    full = (q_addr.size() == depth);
    e_mr = !full;
    e_ar = !full && !mv;
    check("mem_ready", 32'(mem_ready), 32'(e_mr));
    check("alu_ready", 32'(alu_ready), 32'(e_ar));
    check("write_en", 32'(write_en), 32'(q_addr.size() != 0));
    check("write_addr", 32'(write_addr), (q_addr.size() != 0) ? 32'(q_addr[0]) : 32'd0);
    check("data_in", 32'(data_in), (q_addr.size() != 0) ? 32'(q_data[0]) : 32'd0);
    check("pending", 32'(pending), 32'(q_addr.size()));
    model_fwd(ra, hit, fd);
    check("fwd_hit_a", 32'(fwd_hit_a), 32'(hit));
    check("fwd_data_a", 32'(fwd_data_a), 32'(fd));
    model_fwd(rb, hit, fd);
    check("fwd_hit_b", 32'(fwd_hit_b), 32'(hit));
    check("fwd_data_b", 32'(fwd_data_b), 32'(fd));
    // Advance the reference to the state after the coming rising edge.
    if (!rst) begin
      q_addr.delete();
      q_data.delete();
    end else begin
      if (q_addr.size() != 0) begin
        void'(q_addr.pop_front());
        void'(q_data.pop_front());
      end
      if (mv && e_mr) begin
        if (ma != 3'd0) begin q_addr.push_back(ma); q_data.push_back(md); end
      end else if (av && e_ar) begin
        if (aa != 3'd0) begin q_addr.push_back(aa); q_data.push_back(ad); end
      end
    end
  endtask

  task automatic idle(input logic [2:0] ra, input logic [2:0] rb);
    step(1'b1, 1'b0, 3'd0, '0, 1'b0, 3'd0, '0, ra, rb);
  endtask

  initial begin
    reset = 1'b0;
    mem_valid = 1'b0; mem_addr = '0; mem_data = '0;
    alu_valid = 1'b0; alu_addr = '0; alu_data = '0;
    read_addr_a = '0; read_addr_b = '0;
    repeat (2) @(posedge clk);
    // Reset state, with mem_valid exercising alu_ready during reset
    step(1'b0, 1'b1, 3'd3, 16'h1234, 1'b1, 3'd4, 16'h5678, 3'd3, 3'd4);
    step(1'b0, 1'b0, 3'd0, '0, 1'b0, 3'd0, '0, 3'd3, 3'd4);
    // Single memory result, one-cycle latency
    step(1'b1, 1'b1, 3'd3, 16'h00AA, 1'b0, 3'd0, '0, 3'd3, 3'd0);
    idle(3'd3, 3'd0);
    idle(3'd3, 3'd0);
    // Simultaneous mem and alu: alu held, then accepted next cycle
    step(1'b1, 1'b1, 3'd2, 16'h1111, 1'b1, 3'd5, 16'h2222, 3'd2, 3'd5);
    step(1'b1, 1'b0, 3'd0, '0, 1'b1, 3'd5, 16'h2222, 3'd2, 3'd5);
    idle(3'd2, 3'd5);
    idle(3'd2, 3'd5);
    // Back-to-back traffic to the same register with forwarding probes
    step(1'b1, 1'b1, 3'd4, 16'h0001, 1'b0, 3'd0, '0, 3'd4, 3'd0);
    step(1'b1, 1'b1, 3'd4, 16'h0002, 1'b0, 3'd0, '0, 3'd4, 3'd0);
    for (int i = 0; i < 5; i++)
      step(1'b1, 1'b1, 3'(i + 1), 16'(16'h100 + i), 1'b1, 3'd6, 16'hBEEF, 3'(i), 3'd6);
    idle(3'd4, 3'd0);
    // Register 0 is acknowledged but never written
    step(1'b1, 1'b0, 3'd0, '0, 1'b1, 3'd0, 16'hFFFF, 3'd0, 3'd0);
    idle(3'd0, 3'd0);
    // Reset with an entry pending discards it
    step(1'b1, 1'b1, 3'd7, 16'h7777, 1'b0, 3'd0, '0, 3'd7, 3'd7);
    step(1'b0, 1'b1, 3'd6, 16'h6666, 1'b0, 3'd0, '0, 3'd7, 3'd6);
    idle(3'd7, 3'd6);
    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      step(($urandom_range(0, 39) != 0),
           1'($urandom), 3'($urandom_range(0, 7)), 16'($urandom),
           1'($urandom), 3'($urandom_range(0, 7)), 16'($urandom),
           3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
    end
    idle(3'd1, 3'd2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
